// File: rtl/alu_request_arbiter_if.sv
// Signal bundle between the two ALU requesters, the request arbiter and the shared ALU.
// The slave modport is the arbiter's view; the master modport is the requesters/ALU view.
interface alu_request_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FSEL_WIDTH = 5
);

  // Requester side
  logic                  req0;
  logic                  req1;
  logic [FSEL_WIDTH-1:0] fun_sel0;
  logic [FSEL_WIDTH-1:0] fun_sel1;
  logic [DATA_WIDTH-1:0] a0;
  logic [DATA_WIDTH-1:0] a1;
  logic [DATA_WIDTH-1:0] b0;
  logic [DATA_WIDTH-1:0] b1;
  logic                  wf0;
  logic                  wf1;
  logic                  lock0;
  logic                  lock1;
  logic                  done0;
  logic                  done1;
  logic [DATA_WIDTH-1:0] result;
  logic [3:0]            flags;
  logic                  busy;

  // ALU side
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [FSEL_WIDTH-1:0] alu_fun_sel;
  logic                  alu_wf;
  logic [DATA_WIDTH-1:0] alu_out;
  logic [3:0]            alu_flags;

  modport slave (
    input  req0, req1, fun_sel0, fun_sel1, a0, a1, b0, b1, wf0, wf1, lock0, lock1,
    output done0, done1, result, flags, busy,
    output alu_a, alu_b, alu_fun_sel, alu_wf,
    input  alu_out, alu_flags
  );

  modport master (
    output req0, req1, fun_sel0, fun_sel1, a0, a1, b0, b1, wf0, wf1, lock0, lock1,
    input  done0, done1, result, flags, busy,
    input  alu_a, alu_b, alu_fun_sel, alu_wf,
    output alu_out, alu_flags
  );

endinterface

// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters: IDLE -> ISSUE -> CAPTURE -> DONE.
// Optional grant locking for multi-word carry chains is enabled by defining ALU_ARB_LOCK_EN.
module alu_request_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int FSEL_WIDTH   = 5,
  parameter int LOCK_TIMEOUT = 4
) (
  input logic                  clk,
  input logic                  rst,
  alu_request_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state;
  logic                  grant;
  logic                  rr_ptr;

  logic                  done0;
  logic                  done1;
  logic                  busy;
  logic [DATA_WIDTH-1:0] result;
  logic [3:0]            flags;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [FSEL_WIDTH-1:0] alu_fun_sel;
  logic                  alu_wf;

  logic                  pick_valid;
  logic                  pick;
  logic [FSEL_WIDTH-1:0] pick_fun_sel;
  logic [DATA_WIDTH-1:0] pick_a;
  logic [DATA_WIDTH-1:0] pick_b;
  logic                  pick_wf;

`ifdef ALU_ARB_LOCK_EN
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_TIMEOUT - 1);

  logic                  lock_active;
  logic                  lock_owner;
  logic [3:0]            lock_timer;
  logic                  owner_req;

  assign owner_req = lock_owner ? bus.req1 : bus.req0;
`else
  logic                  lock_unused;

  assign lock_unused = bus.lock0 ^ bus.lock1 ^ (LOCK_TIMEOUT == 0);
`endif

  // Winner: the lone requester, or on a tie the one that was not served last.
  always_comb begin
    pick_valid = bus.req0 | bus.req1;
    pick       = bus.req1 & (~bus.req0 | ~rr_ptr);
`ifdef ALU_ARB_LOCK_EN
    if (lock_active) begin
      pick_valid = owner_req;
      pick       = lock_owner;
    end
`endif
  end

  assign pick_fun_sel = pick ? bus.fun_sel1 : bus.fun_sel0;
  assign pick_a       = pick ? bus.a1       : bus.a0;
  assign pick_b       = pick ? bus.b1       : bus.b0;
  assign pick_wf      = pick ? bus.wf1      : bus.wf0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 1'b0;
      rr_ptr      <= 1'b1;
      done0       <= 1'b0;
      done1       <= 1'b0;
      busy        <= 1'b0;
      result      <= '0;
      flags       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_fun_sel <= '0;
      alu_wf      <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
      lock_timer  <= '0;
`endif
    end else begin
      case (state)
        // IDLE: snapshot the winner's operation straight into the ALU drive registers
        IDLE: begin
          if (pick_valid) begin
            grant       <= pick;
            alu_a       <= pick_a;
            alu_b       <= pick_b;
            alu_fun_sel <= pick_fun_sel;
            alu_wf      <= pick_wf;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
`ifdef ALU_ARB_LOCK_EN
          // An idle lock owner forfeits the lock after LOCK_TIMEOUT blocked cycles.
          if (lock_active && !owner_req) begin
            if (lock_timer == LOCK_LAST) begin
              lock_active <= 1'b0;
              lock_timer  <= '0;
            end else begin
              lock_timer <= lock_timer + 4'd1;
            end
          end else begin
            lock_timer <= '0;
          end
`endif
        end

        // ISSUE: ALU is driven this cycle; its flag register updates on this edge
        ISSUE: begin
          result <= bus.alu_out;
          alu_a  <= '0;
          alu_b  <= '0;
          alu_wf <= 1'b0;
          state  <= CAPTURE;
        end

        // CAPTURE: flags now reflect the operation (or are unchanged when WF was 0)
        CAPTURE: begin
          flags <= bus.alu_flags;
          done0 <= ~grant;
          done1 <= grant;
          state <= DONE;
        end

        // DONE: one-cycle completion pulse, then hand priority to the other side
        DONE: begin
          done0  <= 1'b0;
          done1  <= 1'b0;
          busy   <= 1'b0;
          rr_ptr <= grant;
          state  <= IDLE;
`ifdef ALU_ARB_LOCK_EN
          lock_active <= grant ? bus.lock1 : bus.lock0;
          lock_owner  <= grant;
          lock_timer  <= '0;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done0       = done0;
  assign bus.done1       = done1;
  assign bus.busy        = busy;
  assign bus.result      = result;
  assign bus.flags       = flags;
  assign bus.alu_a       = alu_a;
  assign bus.alu_b       = alu_b;
  assign bus.alu_fun_sel = alu_fun_sel;
  assign bus.alu_wf      = alu_wf;

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Bench for alu_request_arbiter with a stand-in ALU and a transaction-level reference model.
// Define ALU_ARB_LOCK_EN for both RTL and bench to include the grant-lock scenarios.
module tb_alu_request_arbiter;

  localparam int DATA_WIDTH   = 16;
  localparam int FSEL_WIDTH   = 5;
  localparam int LOCK_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int errors = 0;
  int checks = 0;

  alu_request_arbiter_if #(.DATA_WIDTH(DATA_WIDTH), .FSEL_WIDTH(FSEL_WIDTH)) bus ();

  alu_request_arbiter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FSEL_WIDTH  (FSEL_WIDTH),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ALU behaviour: returns {Z,C,N,O,result}; C/O kept for pure data moves and logic ops.
  function automatic logic [19:0] alu_calc(input logic [4:0] fs, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] fl);
    logic [16:0] s;
    logic [15:0] r;
    logic [7:0]  r8;
    logic        z, c, n, o;
    s = '0; r = '0; r8 = '0;
    c = fl[2]; o = fl[0];
    case (fs)
      5'b10000: r = a;
      5'b10100: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0]; c = s[16]; o = (a[15] == b[15]) && (r[15] != a[15]);
      end
      5'b10101: begin
        s = {1'b0, a} + {1'b0, b} + 17'(fl[2]);
        r = s[15:0]; c = s[16]; o = (a[15] == b[15]) && (r[15] != a[15]);
      end
      5'b00110: begin
        r8 = a[7:0] - b[7:0];
        r = {8'h00, r8}; c = (a[7:0] < b[7:0]); o = (a[7] != b[7]) && (r8[7] != a[7]);
      end
      5'b10111: r = a & b;
      default:  r = a ^ b;
    endcase
    if (fs == 5'b00110) begin
      z = (r8 == 8'h00); n = r8[7];
    end else begin
      z = (r == 16'h0000); n = r[15];
    end
    return {z, c, n, o, r};
  endfunction

  // Stand-in ALU: combinational result, flag register updated when WF is high, never reset.
  logic [3:0]  alu_flag_reg = 4'b0000;
  logic [19:0] alu_comb;
  assign alu_comb      = alu_calc(bus.alu_fun_sel, bus.alu_a, bus.alu_b, alu_flag_reg);
  assign bus.alu_out   = alu_comb[15:0];
  assign bus.alu_flags = alu_flag_reg;
  always @(posedge clk) if (bus.alu_wf) alu_flag_reg <= alu_comb[19:16];

  // Reference model state
  logic [3:0]  model_flags = 4'b0000;
  int          last_served = 1;
  logic [15:0] exp_result  = 16'h0000;
  logic [3:0]  exp_flags   = 4'b0000;
  logic [4:0]  fs_list [5] = '{5'b10000, 5'b10100, 5'b10101, 5'b00110, 5'b10111};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_done0"}, 32'(bus.done0), 32'd0);
    check({tag, "_done1"}, 32'(bus.done1), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
    check({tag, "_flags"}, 32'(bus.flags), 32'd0);
    check({tag, "_alu_a"}, 32'(bus.alu_a), 32'd0);
    check({tag, "_alu_b"}, 32'(bus.alu_b), 32'd0);
    check({tag, "_alu_fsel"}, 32'(bus.alu_fun_sel), 32'd0);
    check({tag, "_alu_wf"}, 32'(bus.alu_wf), 32'd0);
  endtask

  // Raise the given requests together and check every cycle until all are served.
  task automatic serve(input logic r0, input logic r1,
                       input logic [4:0] f0, input logic [15:0] x0, input logic [15:0] y0, input logic w0,
                       input logic [4:0] f1, input logic [15:0] x1, input logic [15:0] y1, input logic w1);
    int          n, slot, ph;
    int          who [2];
    logic [4:0]  ofs [2];
    logic [15:0] oa [2];
    logic [15:0] ob [2];
    logic [15:0] ores [2];
    logic        ow [2];
    logic [3:0]  ofl [2];
    logic [19:0] cr;
    n = 0;
    who[0] = 0; who[1] = 0;
    if (r0 && r1) begin
      who[0] = (last_served == 0) ? 1 : 0; who[1] = 1 - who[0]; n = 2;
    end else if (r0) begin
      who[0] = 0; n = 1;
    end else if (r1) begin
      who[0] = 1; n = 1;
    end
    for (int k = 0; k < n; k++) begin
      ofs[k] = (who[k] == 0) ? f0 : f1;
      oa[k]  = (who[k] == 0) ? x0 : x1;
      ob[k]  = (who[k] == 0) ? y0 : y1;
      ow[k]  = (who[k] == 0) ? w0 : w1;
      cr = alu_calc(ofs[k], oa[k], ob[k], model_flags);
      ores[k] = cr[15:0];
      if (ow[k]) model_flags = cr[19:16];
      ofl[k] = model_flags;
      last_served = who[k];
    end
    bus.fun_sel0 = f0; bus.a0 = x0; bus.b0 = y0; bus.wf0 = w0;
    bus.fun_sel1 = f1; bus.a1 = x1; bus.b1 = y1; bus.wf1 = w1;
    bus.req0 = r0; bus.req1 = r1;
    for (int cyc = 1; cyc <= 4 * n; cyc++) begin
      @(posedge clk); @(negedge clk);
      slot = (cyc - 1) / 4;
      ph   = cyc - 4 * slot;
      if (ph == 2) exp_result = ores[slot];
      if (ph == 3) exp_flags = ofl[slot];
      check("busy", 32'(bus.busy), 32'(ph != 4));
      check("done0", 32'(bus.done0), 32'(ph == 3 && who[slot] == 0));
      check("done1", 32'(bus.done1), 32'(ph == 3 && who[slot] == 1));
      check("alu_a", 32'(bus.alu_a), (ph == 1) ? 32'(oa[slot]) : 32'd0);
      check("alu_b", 32'(bus.alu_b), (ph == 1) ? 32'(ob[slot]) : 32'd0);
      check("alu_wf", 32'(bus.alu_wf), (ph == 1) ? 32'(ow[slot]) : 32'd0);
      check("alu_fun_sel", 32'(bus.alu_fun_sel), 32'(ofs[slot]));
      check("result", 32'(bus.result), 32'(exp_result));
      check("flags", 32'(bus.flags), 32'(exp_flags));
      if (ph == 3) begin
        if (who[slot] == 0) bus.req0 = 1'b0;
        else bus.req1 = 1'b0;
      end
    end
  endtask

  // Wait (bounded) for the next Done pulse; who = -1 when none arrives.
  task automatic wait_done(output int who, output int cyc);
    int c;
    who = -1; cyc = 0; c = 0;
    while (who < 0 && c < 30) begin
      @(posedge clk); @(negedge clk);
      c++;
      if (bus.done0 || bus.done1) begin
        who = bus.done1 ? 1 : 0;
        cyc = c;
      end
    end
  endtask

  initial begin
    logic [19:0] cr;
    logic        r0, r1;
    int          gap, w, c;
    bus.req0 = 0; bus.req1 = 0; bus.lock0 = 0; bus.lock1 = 0;
    bus.fun_sel0 = '0; bus.fun_sel1 = '0; bus.a0 = '0; bus.a1 = '0;
    bus.b0 = '0; bus.b1 = '0; bus.wf0 = 0; bus.wf1 = 0;

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous requests straight out of reset: requester 0 first
    serve(1, 1, 5'b10100, 16'h1234, 16'h1111, 1, 5'b00110, 16'h0010, 16'h0003, 1);

    // 7FFF + 1: signed overflow into the sign bit
    serve(1, 0, 5'b10100, 16'h7FFF, 16'h0001, 1, 5'b00000, 16'h0000, 16'h0000, 0);
    check("t1_result", 32'(bus.result), 32'h8000);
    check("t1_flags", 32'(bus.flags), 32'b0011);

    // Flag-preserving move: flags unchanged
    serve(1, 0, 5'b10000, 16'h0000, 16'h1234, 0, 5'b00000, 16'h0000, 16'h0000, 0);
    check("t4_result", 32'(bus.result), 32'h0000);
    check("t4_flags", 32'(bus.flags), 32'b0011);

    // 8-bit subtract to zero from requester 1
    serve(0, 1, 5'b00000, 16'h0000, 16'h0000, 0, 5'b00110, 16'h0005, 16'h0005, 1);
    check("t3_result", 32'(bus.result), 32'h0000);
    check("t3_flags", 32'(bus.flags), 32'b1000);

    // Reset during CAPTURE: abort without Done, ALU flags already updated
    bus.req0 = 1; bus.fun_sel0 = 5'b10100; bus.a0 = 16'h0001; bus.b0 = 16'h0002; bus.wf0 = 1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check("t5_busy_capture", 32'(bus.busy), 32'd1);
    cr = alu_calc(5'b10100, 16'h0001, 16'h0002, model_flags);
    model_flags = cr[19:16];
    rst = 1'b1; bus.req0 = 0;
    @(posedge clk); @(negedge clk);
    check_zero("t5_abort");
    rst = 1'b0;
    last_served = 1; exp_result = '0; exp_flags = '0;
    serve(1, 0, 5'b10000, 16'h00AB, 16'h0000, 0, 5'b00000, 16'h0000, 16'h0000, 0);

    // Randomized traffic with idle gaps
    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      serve(r0, r1,
            fs_list[$urandom_range(0, 4)], 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
            fs_list[$urandom_range(0, 4)], 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'({bus.done0, bus.done1}), 32'd0);
      end
    end

`ifdef ALU_ARB_LOCK_EN
    serve(0, 1, 5'b10000, 16'h0000, 16'h0000, 0, 5'b10000, 16'h0042, 16'h0000, 0);
    bus.fun_sel0 = 5'b10000; bus.a0 = 16'h0011; bus.b0 = '0; bus.wf0 = 0;
    bus.fun_sel1 = 5'b10000; bus.a1 = 16'h0022; bus.b1 = '0; bus.wf1 = 0;
    // Owner re-requests while locked: served ahead of the pending requester 1
    bus.req0 = 1; bus.lock0 = 1; bus.req1 = 1;
    wait_done(w, c);
    check("lk_a1_who", 32'(w), 32'd0);
    check("lk_a1_cyc", 32'(c), 32'd3);
    bus.req0 = 0;
    @(posedge clk); @(negedge clk);
    bus.req0 = 1; bus.lock0 = 0;
    wait_done(w, c);
    check("lk_a2_who", 32'(w), 32'd0);
    check("lk_a2_cyc", 32'(c), 32'd3);
    bus.req0 = 0;
    wait_done(w, c);
    check("lk_a3_who", 32'(w), 32'd1);
    check("lk_a3_cyc", 32'(c), 32'd4);
    check("lk_a3_result", 32'(bus.result), 32'h0022);
    bus.req1 = 0;
    @(posedge clk); @(negedge clk);
    // Owner goes quiet: requester 1 waits out the lock timeout
    bus.req0 = 1; bus.lock0 = 1; bus.req1 = 1;
    wait_done(w, c);
    check("lk_b1_who", 32'(w), 32'd0);
    check("lk_b1_cyc", 32'(c), 32'd3);
    bus.req0 = 0;
    wait_done(w, c);
    check("lk_b2_who", 32'(w), 32'd1);
    check("lk_b2_cyc", 32'(c), 32'(4 + LOCK_TIMEOUT));
    bus.req1 = 0; bus.lock0 = 0;
`endif

    @(posedge clk); @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
